// File: rtl/saph_fpu_pkg.sv
// Shared types for the FPU crossbar: 32-bit float container, 2-bit mode index, index-width helper.
// Latency: none (types and constants only).
// Backpressure: none (types and constants only).
package saph_fpu_pkg;

   typedef logic [31:0] float;
   typedef logic [1:0]  fpu_mode_t;

   localparam int FPU_MODES = 4;

   // Width of an index into n items; never narrower than one bit so a single item still gets a port.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/saph_fpu_xbar_if.sv
// Bundle of requester-side and FPU-side signals around the FPU crossbar.
// Latency: none (wiring only).
// Backpressure: req_ready per requester, fpu_ready per FPU.
interface saph_fpu_xbar_if
   import saph_fpu_pkg::*;
#(
   parameter int REQS = 2,
   parameter int FPUS = 2
) ();

   // Requester side
   logic      [REQS-1:0]                req_trig;
   fpu_mode_t [REQS-1:0]                req_mode;
   float      [REQS-1:0]                req_lhs;
   float      [REQS-1:0]                req_rhs;
   logic      [REQS-1:0]                req_ready;
   logic      [REQS-1:0]                req_nomode;
   logic      [REQS-1:0]                resp_valid;
   float      [REQS-1:0]                resp_res;

   // FPU side
   logic      [FPUS-1:0][FPU_MODES-1:0] fpu_has_modes;
   logic      [FPUS-1:0]                fpu_ready;
   logic      [FPUS-1:0]                fpu_trig;
   fpu_mode_t [FPUS-1:0]                fpu_mode;
   float      [FPUS-1:0]                fpu_lhs;
   float      [FPUS-1:0]                fpu_rhs;
   float      [FPUS-1:0]                fpu_res;

   // Crossbar view
   modport slave (
      input  req_trig, req_mode, req_lhs, req_rhs,
      output req_ready, req_nomode, resp_valid, resp_res,
      input  fpu_has_modes, fpu_ready, fpu_res,
      output fpu_trig, fpu_mode, fpu_lhs, fpu_rhs
   );

   // Environment view (lanes plus FPU pool)
   modport master (
      output req_trig, req_mode, req_lhs, req_rhs,
      input  req_ready, req_nomode, resp_valid, resp_res,
      output fpu_has_modes, fpu_ready, fpu_res,
      input  fpu_trig, fpu_mode, fpu_lhs, fpu_rhs
   );

endinterface

// File: rtl/saph_fpu_tagpipe.sv
// Per-FPU return-tag shift register: carries {valid, requester index} alongside the FPU pipeline.
// Latency: LATENCY cycles from issue_vld to ret_vld.
// Backpressure: none; shifts every cycle unconditionally, so issue and retire may coincide.
module saph_fpu_tagpipe
   import saph_fpu_pkg::*;
#(
   parameter int REQS    = 2,
   parameter int LATENCY = 3
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     issue_vld,
   input  logic [idx_w(REQS)-1:0]   issue_idx,
   output logic                     ret_vld,
   output logic [idx_w(REQS)-1:0]   ret_idx
);

   localparam int IW = idx_w(REQS);

   logic [LATENCY-1:0]         vld;
   logic [LATENCY-1:0][IW-1:0] idx;

   // Shift tags one stage per cycle; reset drops everything in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld <= '0;
         idx <= '0;
      end else begin
         vld[0] <= issue_vld;
         idx[0] <= issue_idx;
         for (int s = 1; s < LATENCY; s++) begin
            vld[s] <= vld[s-1];
            idx[s] <= idx[s-1];
         end
      end
   end

   assign ret_vld = vld[LATENCY-1];
   assign ret_idx = idx[LATENCY-1];

endmodule

// File: rtl/saph_fpu_xbar.sv
// Multi-requester to multi-FPU crossbar; grants are combinational, results routed back by tag.
// Latency: grant same cycle, response exactly LATENCY cycles after grant.
// Backpressure: ungranted requesters see req_ready low and hold; no buffering. SAPH_FPU_XBAR_RR_EN enables round-robin.
module saph_fpu_xbar
   import saph_fpu_pkg::*;
#(
   parameter int REQS    = 2,
   parameter int FPUS    = 2,
   parameter int LATENCY = 3
) (
   input  logic           clk,
   input  logic           rst_n,
   saph_fpu_xbar_if.slave bus
);

   localparam int IW = idx_w(REQS);
   typedef logic [IW-1:0] idx_t;

   if (LATENCY < 1) begin : g_bad_latency
      $error("saph_fpu_xbar: LATENCY must be >= 1");
   end
   if (REQS < 1) begin : g_bad_reqs
      $error("saph_fpu_xbar: REQS must be >= 1");
   end
   if (FPUS < 1) begin : g_bad_fpus
      $error("saph_fpu_xbar: FPUS must be >= 1");
   end

   idx_t            rr;
   logic [REQS-1:0] grant;
   logic [REQS-1:0] nomode;
   logic [FPUS-1:0] claimed;
   logic [FPUS-1:0] issue;
   idx_t [FPUS-1:0] fpu_sel;
   logic [FPUS-1:0] ret_vld;
   idx_t [FPUS-1:0] ret_idx;

   // Visit requesters from rr onward; each takes the lowest ready, capable, unclaimed FPU.
   always_comb begin
      int   ri;
      idx_t r;
      logic supported;
      logic done;
      grant     = '0;
      nomode    = '0;
      claimed   = '0;
      fpu_sel   = '0;
      ri        = 0;
      r         = '0;
      supported = 1'b0;
      done      = 1'b0;
      for (int k = 0; k < REQS; k++) begin
         ri = int'(rr) + k;
         if (ri >= REQS) ri -= REQS;
         r = idx_t'(ri);
         supported = 1'b0;
         for (int f = 0; f < FPUS; f++) begin
            if (bus.fpu_has_modes[f][bus.req_mode[r]]) supported = 1'b1;
         end
         done = 1'b0;
         if (bus.req_trig[r] && !supported) begin
            nomode[r] = 1'b1;
         end else if (bus.req_trig[r]) begin
            for (int f = 0; f < FPUS; f++) begin
               if (!done && bus.fpu_ready[f] && !claimed[f] &&
                   bus.fpu_has_modes[f][bus.req_mode[r]]) begin
                  claimed[f] = 1'b1;
                  fpu_sel[f] = r;
                  grant[r]   = 1'b1;
                  done       = 1'b1;
               end
            end
         end
      end
   end

`ifdef SAPH_FPU_XBAR_RR_EN
   idx_t rr_nxt;
   logic any_grant;

   // Next pointer sits one past the granted requester nearest the head of the visiting order.
   always_comb begin
      int ri;
      rr_nxt    = rr;
      any_grant = 1'b0;
      ri        = 0;
      for (int k = REQS - 1; k >= 0; k--) begin
         ri = int'(rr) + k;
         if (ri >= REQS) ri -= REQS;
         if (grant[idx_t'(ri)]) begin
            any_grant = 1'b1;
            rr_nxt    = (ri == REQS - 1) ? '0 : idx_t'(ri + 1);
         end
      end
   end

   // Pointer moves only on cycles that produced at least one grant.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)         rr <= '0;
      else if (any_grant) rr <= rr_nxt;
   end
`else
   // Fixed priority: requester 0 always heads the visiting order.
   assign rr = '0;
`endif

   // Drive issue and handshake outputs; all held quiet while reset is asserted.
   always_comb begin
      issue          = claimed & {FPUS{rst_n}};
      bus.fpu_trig   = issue;
      bus.fpu_mode   = '0;
      bus.fpu_lhs    = '0;
      bus.fpu_rhs    = '0;
      for (int f = 0; f < FPUS; f++) begin
         if (issue[f]) begin
            bus.fpu_mode[f] = bus.req_mode[fpu_sel[f]];
            bus.fpu_lhs[f]  = bus.req_lhs[fpu_sel[f]];
            bus.fpu_rhs[f]  = bus.req_rhs[fpu_sel[f]];
         end
      end
      bus.req_ready  = grant & {REQS{rst_n}};
      bus.req_nomode = nomode & {REQS{rst_n}};
   end

   for (genvar f = 0; f < FPUS; f++) begin : g_tag
      saph_fpu_tagpipe #(
         .REQS    (REQS),
         .LATENCY (LATENCY)
      ) u_tagpipe (
         .clk       (clk),
         .rst_n     (rst_n),
         .issue_vld (issue[f]),
         .issue_idx (fpu_sel[f]),
         .ret_vld   (ret_vld[f]),
         .ret_idx   (ret_idx[f])
      );
   end

   // Route retiring results home; a requester is granted once per cycle, so OR-merge never collides.
   always_comb begin
      bus.resp_valid = '0;
      bus.resp_res   = '0;
      for (int f = 0; f < FPUS; f++) begin
         if (ret_vld[f]) begin
            bus.resp_valid[ret_idx[f]] = 1'b1;
            bus.resp_res[ret_idx[f]]   = bus.resp_res[ret_idx[f]] | bus.fpu_res[f];
         end
      end
   end

endmodule

// File: doc/saph_fpu_xbar.md
# saph_fpu_xbar

Multi-requester, multi-FPU floating-point crossbar. Accepts up to REQS concurrent requests per cycle from shader lanes, routes each to a ready FPU that supports the requested mode, and returns each result to its originating requester exactly LATENCY cycles later. It sits between the GPU lane array and the pool of pipelined FPU units and replaces single-requester demultiplexing.

## Interface
- REQS, 2, number of requester channels (≥1)
- FPUS, 2, number of FPU units (≥1)
- LATENCY, 3, fixed FPU pipeline latency in cycles, identical for every FPU (≥1)
- clk  in  1  core clock
- rst_n  in  1  reset, asynchronous, active-low
- req_trig  in  REQS  request valid per requester
- req_mode  in  REQS×2  operation mode index (fpu_mode_t)
- req_lhs / req_rhs  in  REQS×32  operands (float)
- req_ready  out  REQS  request accepted this cycle (combinational)
- req_nomode  out  REQS  req_trig high and no FPU supports req_mode (combinational)
- resp_valid  out  REQS  result valid for one cycle
- resp_res  out  REQS×32  result; zero when resp_valid low
- fpu_has_modes  in  FPUS×4  supported-mode mask per FPU
- fpu_ready  in  FPUS  FPU can accept an operation this cycle
- fpu_trig  out  FPUS  issue strobe
- fpu_mode  out  FPUS×2, fpu_lhs / fpu_rhs  out  FPUS×32  issued operation
- fpu_res  in  FPUS×32  FPU result, valid LATENCY cycles after its fpu_trig

## Operation
- Per cycle, requesters are visited in priority order starting at pointer `rr`. Each requester with req_trig claims the lowest-index FPU that is ready, has fpu_has_modes[f][req_mode[r]] set, and is not yet claimed this cycle.
- Claim → fpu_trig[f]=1, fpu_mode/lhs/rhs = requester's, req_ready[r]=1. Unclaimed FPUs: fpu_trig=0, operand outputs 0.
- Requesters without a claim see req_ready=0 and must hold their request; no internal request buffering.
- Each FPU has a tag pipeline of LATENCY stages: {valid, requester index}. Issue writes stage 0; the final stage selects fpu_res[f] onto resp_res[r] and raises resp_valid[r].
- Two FPUs can never target the same requester in one cycle, because a requester is granted at most once per cycle. Response OR-merging is therefore safe.
- req_nomode requesters are skipped and never granted. Behaviour is undefined if the requester keeps req_trig asserted; the bench checks the flag only.
- Pointer update: if ≥1 grant occurred, rr ← (highest-priority-order granted requester index + 1) mod REQS. Otherwise rr is unchanged. Wrap from REQS-1 to 0.

## Timing
- Grant is combinational in cycle t. The response is asserted in cycle t+LATENCY, taken combinationally from fpu_res.
- Full throughput: each FPU accepts one op per cycle while fpu_ready is high.
- Reset (rst_n low, any time): rr=0, all tag stages invalid, resp_valid=0, resp_res=0. fpu_trig and req_ready are forced to 0 while in reset.
- Reset mid-flight: in-flight results are discarded. No resp_valid is raised for operations issued before reset, even if fpu_res arrives afterward.
- A simultaneous issue and retire on the same FPU is legal; the pipeline shifts every cycle unconditionally.
- Elaboration $error if LATENCY<1, REQS<1 or FPUS<1.

## Configuration
- SAPH_FPU_XBAR_RR_EN defined: round-robin arbitration via the rr register as above.
- Undefined: fixed priority with requester 0 highest. The rr register is not instantiated (constant 0).

## Structure
- saph_fpu_pkg holds: `float` typedef (32-bit), `fpu_mode_t` (2-bit), constant FPU_MODES=4.
- Sub-module saph_fpu_tagpipe, one per FPU: the LATENCY-deep valid/index shift register with async reset, parametrised on REQS and LATENCY.

## Test plan
- REQS=2, FPUS=2, LATENCY=3, all modes on both FPUs; both requesters trig mode 0, 1.0+2.0 and 3.0+4.0 → both req_ready=1; r0→FPU0, r1→FPU1. Three cycles later: resp_valid=2'b11, resp_res carries each FPU's model result.
- FPUS=1, both requesters trig continuously for 4 cycles with RR_EN → grants alternate r0,r1,r0,r1. Without the macro → r0 granted all 4 cycles.
- FPU0 has_modes=4'b0001, FPU1=4'b0010; r0 requests mode 1 → routed to FPU1. r1 requests mode 3 → req_nomode[1]=1, req_ready[1]=0, no fpu_trig.
- fpu_ready=2'b00 for 2 cycles then 2'b01 → req_ready low for 2 cycles, then one grant to FPU0. rr only advances on the grant cycle.
- Issue on r1 at cycle 10, assert rst_n=0 at cycle 11 for 1 cycle → no resp_valid at cycle 13. All outputs zero during reset.
- Back-to-back issue for 8 cycles on a single FPU → 8 consecutive resp_valid pulses, in order, each exactly LATENCY cycles after its grant.
